// File: rtl/fwd_pkg.sv
// fwd_pkg: forwarding-select type and encodings shared by the forwarding unit
package fwd_pkg;
  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_NONE  = 2'b00;
  localparam fwd_sel_t FWD_MEMWB = 2'b01;
  localparam fwd_sel_t FWD_EXMEM = 2'b10;
endpackage

// File: rtl/forwarding_unit_if.sv
// forwarding_unit_if: pipeline hazard inputs and operand-select outputs; counter signals exist only with FWD_STATS_EN
interface forwarding_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W = 16
);
  import fwd_pkg::*;
  logic [REG_ADDR_W-1:0] Rs1_ID_EX;
  logic [REG_ADDR_W-1:0] Rs2_ID_EX;
  logic [REG_ADDR_W-1:0] Rd_EX_MEM;
  logic [REG_ADDR_W-1:0] Rd_MEM_WB;
  logic Reg_Write_EX_MEM;
  logic Reg_Write_MEM_WB;
  fwd_sel_t F1;
  fwd_sel_t F2;
  fwd_sel_t F1_q;
  fwd_sel_t F2_q;
`ifdef FWD_STATS_EN
  logic [CNT_W-1:0] fwd_exmem_cnt;
  logic [CNT_W-1:0] fwd_memwb_cnt;
  modport master (
    output Rs1_ID_EX, Rs2_ID_EX, Rd_EX_MEM, Rd_MEM_WB, Reg_Write_EX_MEM, Reg_Write_MEM_WB,
    input F1, F2, F1_q, F2_q, fwd_exmem_cnt, fwd_memwb_cnt
  );
  modport slave (
    input Rs1_ID_EX, Rs2_ID_EX, Rd_EX_MEM, Rd_MEM_WB, Reg_Write_EX_MEM, Reg_Write_MEM_WB,
    output F1, F2, F1_q, F2_q, fwd_exmem_cnt, fwd_memwb_cnt
  );
`else
  modport master (
    output Rs1_ID_EX, Rs2_ID_EX, Rd_EX_MEM, Rd_MEM_WB, Reg_Write_EX_MEM, Reg_Write_MEM_WB,
    input F1, F2, F1_q, F2_q
  );
  modport slave (
    input Rs1_ID_EX, Rs2_ID_EX, Rd_EX_MEM, Rd_MEM_WB, Reg_Write_EX_MEM, Reg_Write_MEM_WB,
    output F1, F2, F1_q, F2_q
  );
`endif
endinterface

// File: rtl/fwd_select.sv
// fwd_select: single-operand forwarding priority compare, EX/MEM over MEM/WB, x0 never forwards
module fwd_select
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rd_exmem,
  input  logic [REG_ADDR_W-1:0] rd_memwb,
  input  logic                  we_exmem,
  input  logic                  we_memwb,
  output fwd_sel_t              sel
);
  logic hit_exmem;
  logic hit_memwb;
  // match each stage's writer against the source; the newer EX/MEM result wins
  always_comb begin
    hit_exmem = we_exmem && (rd_exmem != '0) && (rd_exmem == rs);
    hit_memwb = we_memwb && (rd_memwb != '0) && (rd_memwb == rs);
    sel = hit_exmem ? FWD_EXMEM : hit_memwb ? FWD_MEMWB : FWD_NONE;
  end
endmodule

// File: rtl/forwarding_unit.sv
// forwarding_unit: operand forwarding selects with registered copies; define FWD_STATS_EN for saturating forward counters
module forwarding_unit
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  forwarding_unit_if.slave bus
);
  if (REG_ADDR_W < 1 || CNT_W < 2) begin : g_bad_param
    $error("forwarding_unit: REG_ADDR_W must be >= 1 and CNT_W >= 2");
  end
  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_sel1 (
    .rs(bus.Rs1_ID_EX), .rd_exmem(bus.Rd_EX_MEM), .rd_memwb(bus.Rd_MEM_WB),
    .we_exmem(bus.Reg_Write_EX_MEM), .we_memwb(bus.Reg_Write_MEM_WB), .sel(bus.F1)
  );
  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_sel2 (
    .rs(bus.Rs2_ID_EX), .rd_exmem(bus.Rd_EX_MEM), .rd_memwb(bus.Rd_MEM_WB),
    .we_exmem(bus.Reg_Write_EX_MEM), .we_memwb(bus.Reg_Write_MEM_WB), .sel(bus.F2)
  );
  // one-cycle registered copy of both selects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.F1_q <= FWD_NONE;
      bus.F2_q <= FWD_NONE;
    end else begin
      bus.F1_q <= bus.F1;
      bus.F2_q <= bus.F2;
    end
  end
`ifdef FWD_STATS_EN
  logic [1:0]     n_exmem;
  logic [1:0]     n_memwb;
  logic [CNT_W:0] sum_exmem;
  logic [CNT_W:0] sum_memwb;
  // count operands taking each bypass this cycle; carry-out means saturate
  always_comb begin
    n_exmem = {1'b0, bus.F1 == FWD_EXMEM} + {1'b0, bus.F2 == FWD_EXMEM};
    n_memwb = {1'b0, bus.F1 == FWD_MEMWB} + {1'b0, bus.F2 == FWD_MEMWB};
    sum_exmem = {1'b0, bus.fwd_exmem_cnt} + (CNT_W+1)'(n_exmem);
    sum_memwb = {1'b0, bus.fwd_memwb_cnt} + (CNT_W+1)'(n_memwb);
  end
  // saturating forward-event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.fwd_exmem_cnt <= '0;
      bus.fwd_memwb_cnt <= '0;
    end else begin
      bus.fwd_exmem_cnt <= sum_exmem[CNT_W] ? '1 : sum_exmem[CNT_W-1:0];
      bus.fwd_memwb_cnt <= sum_memwb[CNT_W] ? '1 : sum_memwb[CNT_W-1:0];
    end
  end
`endif
endmodule

// File: tb/tb_forwarding_unit.sv
// tb_forwarding_unit: vector table with scoreboard for registered selects, plus reset and counter sequences
module tb_forwarding_unit;
  import fwd_pkg::*;
  localparam int AW = 5;
  localparam int CW = 4;
  typedef struct {
    logic [AW-1:0] rs1, rs2, rd_em, rd_mw;
    logic we_em, we_mw;
    fwd_sel_t f1, f2;
  } vec_t;
  typedef struct { fwd_sel_t f1, f2; } exp_t;
  logic clk = 0;
  logic rst_n = 1;
  int applied = 0;
  int miscompares = 0;
  vec_t vecs[13];
  exp_t sb[$];
  exp_t e;
  always #5 clk = ~clk;
  forwarding_unit_if #(.REG_ADDR_W(AW), .CNT_W(CW)) bus();
  forwarding_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.Rs1_ID_EX = v.rs1;
    bus.Rs2_ID_EX = v.rs2;
    bus.Rd_EX_MEM = v.rd_em;
    bus.Rd_MEM_WB = v.rd_mw;
    bus.Reg_Write_EX_MEM = v.we_em;
    bus.Reg_Write_MEM_WB = v.we_mw;
  endtask

  initial begin
    vecs[0]  = '{1, 2, 3, 4, 0, 0, FWD_NONE, FWD_NONE};
    vecs[1]  = '{1, 2, 1, 4, 1, 0, FWD_EXMEM, FWD_NONE};
    vecs[2]  = '{1, 2, 3, 1, 0, 1, FWD_MEMWB, FWD_NONE};
    vecs[3]  = '{1, 2, 2, 4, 1, 0, FWD_NONE, FWD_EXMEM};
    vecs[4]  = '{1, 2, 3, 2, 0, 1, FWD_NONE, FWD_MEMWB};
    vecs[5]  = '{3, 3, 3, 3, 1, 1, FWD_EXMEM, FWD_EXMEM};
    vecs[6]  = '{0, 2, 0, 4, 1, 0, FWD_NONE, FWD_NONE};
    vecs[7]  = '{0, 0, 0, 0, 1, 1, FWD_NONE, FWD_NONE};
    vecs[8]  = '{5, 5, 5, 7, 0, 1, FWD_NONE, FWD_NONE};
    vecs[9]  = '{5, 7, 5, 7, 1, 1, FWD_EXMEM, FWD_MEMWB};
    vecs[10] = '{7, 5, 9, 7, 1, 1, FWD_MEMWB, FWD_NONE};
    vecs[11] = '{31, 31, 31, 31, 0, 1, FWD_MEMWB, FWD_MEMWB};
    vecs[12] = '{4, 4, 6, 4, 1, 1, FWD_MEMWB, FWD_MEMWB};
    drive(vecs[0]);
    #1 rst_n = 0;
    #1;
    check("reset_F1_q", bus.F1_q, FWD_NONE);
    check("reset_F2_q", bus.F2_q, FWD_NONE);
    check("reset_F1_valid", bus.F1, FWD_NONE);
`ifdef FWD_STATS_EN
    check("reset_exmem_cnt", bus.fwd_exmem_cnt, 0);
    check("reset_memwb_cnt", bus.fwd_memwb_cnt, 0);
`endif
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      sb.push_back('{vecs[i].f1, vecs[i].f2});
      #1;
      check($sformatf("F1[%0d]", i), bus.F1, vecs[i].f1);
      check($sformatf("F2[%0d]", i), bus.F2, vecs[i].f2);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        check("scoreboard_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        check($sformatf("F1_q[%0d]", i), bus.F1_q, e.f1);
        check($sformatf("F2_q[%0d]", i), bus.F2_q, e.f2);
      end
    end
    @(negedge clk);
    rst_n = 0;
    #1;
    check("midreset_F1_q", bus.F1_q, FWD_NONE);
    check("midreset_F2_q", bus.F2_q, FWD_NONE);
    check("midreset_F1_valid", bus.F1, FWD_MEMWB);
    check("midreset_F2_valid", bus.F2, FWD_MEMWB);
`ifdef FWD_STATS_EN
    check("midreset_memwb_cnt", bus.fwd_memwb_cnt, 0);
`endif
    @(posedge clk);
    #1;
    check("held_reset_F1_q", bus.F1_q, FWD_NONE);
    @(negedge clk);
    rst_n = 1;
    drive('{6, 6, 6, 2, 1, 0, FWD_EXMEM, FWD_EXMEM});
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_F1_q", bus.F1_q, FWD_EXMEM);
    check("post_reset_F2_q", bus.F2_q, FWD_EXMEM);
`ifdef FWD_STATS_EN
    check("exmem_cnt_3cyc", bus.fwd_exmem_cnt, 6);
    check("memwb_cnt_3cyc", bus.fwd_memwb_cnt, 0);
    repeat (4) @(posedge clk);
    #1;
    check("exmem_cnt_max_m1", bus.fwd_exmem_cnt, 14);
    @(posedge clk);
    #1;
    check("exmem_cnt_sat", bus.fwd_exmem_cnt, 15);
    @(posedge clk);
    #1;
    check("exmem_cnt_hold", bus.fwd_exmem_cnt, 15);
`endif
    if (sb.size() != 0) check("scoreboard_leftover", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule

// File: doc/forwarding_unit.md
FORWARDING_UNIT -- requirements
Module: forwarding_unit

Interface
REQ-001 Parameter REG_ADDR_W, default 5, register-index width; all register-index ports SHALL use this width.
REQ-002 Parameter CNT_W, default 16, statistics counter width (used only when FWD_STATS_EN is defined).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Rs1_ID_EX  input  REG_ADDR_W  source register 1 of the instruction in EX.
REQ-006 Rs2_ID_EX  input  REG_ADDR_W  source register 2 of the instruction in EX.
REQ-007 Rd_EX_MEM  input  REG_ADDR_W  destination register in the EX/MEM stage.
REQ-008 Rd_MEM_WB  input  REG_ADDR_W  destination register in the MEM/WB stage.
REQ-009 Reg_Write_EX_MEM  input  1  EX/MEM instruction writes Rd.
REQ-010 Reg_Write_MEM_WB  input  1  MEM/WB instruction writes Rd.
REQ-011 F1  output  2  operand-1 mux select, combinational.
REQ-012 F2  output  2  operand-2 mux select, combinational.
REQ-013 F1_q, F2_q  output  2 each  F1/F2 registered one cycle.
REQ-014 fwd_exmem_cnt, fwd_memwb_cnt  output  CNT_W each  forwarding-event counters (present only with FWD_STATS_EN).

Function
REQ-015 Encoding SHALL be 00 = register file, 01 = MEM/WB result, 10 = EX/MEM result; 11 SHALL never be driven.
REQ-016 For operand n (Rs = Rs1_ID_EX or Rs2_ID_EX), Fn SHALL be 10 if Reg_Write_EX_MEM=1, Rd_EX_MEM!=0 and Rd_EX_MEM==Rs.
REQ-017 Otherwise Fn SHALL be 01 if Reg_Write_MEM_WB=1, Rd_MEM_WB!=0 and Rd_MEM_WB==Rs.
REQ-018 Otherwise Fn SHALL be 00.
REQ-019 When both stages match the same Rs, EX/MEM SHALL win (10).
REQ-020 A matching Rd with its write enable deasserted SHALL NOT forward.
REQ-021 Register index 0 SHALL never forward, even when the write enable is set.
REQ-022 F1 and F2 SHALL be evaluated independently; both may select the same source in the same cycle.
REQ-023 F1/F2 SHALL be pure combinational functions of the inputs: zero latency, no dependence on clk or rst_n.
REQ-024 F1_q/F2_q SHALL equal F1/F2 sampled at the previous rising clk edge.

Reset
REQ-025 While rst_n=0, F1_q/F2_q SHALL be 00 and the counters SHALL be 0, asynchronously.
REQ-026 F1/F2 SHALL remain valid during reset.
REQ-027 Reset asserted mid-operation SHALL clear all state immediately; counting SHALL resume at the first rising edge after deassertion.

Configuration
REQ-028 With macro FWD_STATS_EN defined, on each rising edge fwd_exmem_cnt SHALL add the number of operands (0..2) selecting 10, and fwd_memwb_cnt SHALL add the number selecting 01.
REQ-029 Each counter SHALL saturate at its all-ones value.
REQ-030 Without FWD_STATS_EN, the counters, their ports and their logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-031 Shared package fwd_pkg SHALL hold the select-type typedef (2 bits) and the constants FWD_NONE=00, FWD_MEMWB=01, FWD_EXMEM=10.
REQ-032 Sub-module fwd_select SHALL implement the single-operand priority compare (REQ-016..021) and SHALL be instantiated once per operand.

Verification
REQ-033 Rs1=1, Rs2=2, Rd_EX_MEM=3, Rd_MEM_WB=4, both writes=0 -> F1=00, F2=00.
REQ-034 Rd_EX_MEM=1, Reg_Write_EX_MEM=1, Reg_Write_MEM_WB=0 -> F1=10, F2=00. Then Reg_Write_EX_MEM=0, Reg_Write_MEM_WB=1, Rd_MEM_WB=1 -> F1=01, F2=00.
REQ-035 Rd_EX_MEM=2 with its write enabled -> F2=10. Then Rd_MEM_WB=2 with only the MEM/WB write enabled -> F2=01, F1=00.
REQ-036 Rs1=Rs2=3, Rd_EX_MEM=Rd_MEM_WB=3, both writes=1 -> F1=10, F2=10 (priority). Rs1=0 with Rd_EX_MEM=0 and the write enabled -> F1=00.
REQ-037 Assert rst_n=0 between clock edges -> F1_q/F2_q and the counters read 0 immediately. Hold a double EX/MEM match for 3 cycles with FWD_STATS_EN -> fwd_exmem_cnt=6.
REQ-038 Preload a counter to all-ones minus 1, then apply a double match -> the counter holds at all-ones.
